// File: rtl/nes_ppu_pkg.sv
// Shared PPU definitions: register decode addresses, OAM size and the OAM write entry.
package nes_ppu_pkg;

  localparam logic [15:0] OAMADDR_REG = 16'h2003;
  localparam logic [15:0] OAMDATA_REG = 16'h2004;
  localparam int          OAM_DEPTH   = 256;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } oam_wr_t;

endpackage

// File: rtl/oam_wr_fifo.sv
// Pending OAM write FIFO. It keeps write order, accepts a push while full when
// a pop happens in the same cycle, and gives the youngest entry matching an address.
module oam_wr_fifo
  import nes_ppu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  oam_wr_t       push_entry,
  input  logic          pop,
  output oam_wr_t       head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  input  logic [7:0]    lk_addr,
  output logic          lk_hit,
  output logic [7:0]    lk_data
);

  oam_wr_t        slots [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic           push_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = slots[rd_ptr];
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);

  // Entry storage; contents need no reset because count qualifies them.
  always_ff @(posedge clk) begin
    if (push_ok) slots[wr_ptr] <= push_entry;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Walk the valid entries from oldest to youngest; the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    lk_hit  = 1'b0;
    lk_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (slots[idx].addr == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = slots[idx].data;
      end
    end
  end

endmodule

// File: rtl/oam_reg_port.sv
// OAM register responder: decodes OAMADDR/OAMDATA cycles, owns the 256x8 OAM,
// arbitrates its single port and buffers writes that collide with PPU reads.
module oam_reg_port
  import nes_ppu_pkg::*;
#(
  parameter int         PEND_DEPTH     = 2,
  parameter logic [7:0] RD_COLLIDE_VAL = 8'hFF,
  localparam int CW = $clog2(PEND_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   cpu_addr,
  input  logic [7:0]    cpu_data_in,
  input  logic          cpu_write_en,
  output logic [7:0]    cpu_data_out,
  input  logic          ppu_rd_en,
  input  logic [7:0]    ppu_rd_addr,
  output logic [7:0]    ppu_rd_data,
  output logic [7:0]    oam_addr_out,
  output logic [CW-1:0] pend_count,
  output logic          wr_drop
);

  logic [7:0] mem [OAM_DEPTH];

  logic       wr_oamaddr, wr_oamdata, rd_oamaddr, rd_oamdata;
  logic       cpu_rd_gnt, direct_wr, fifo_push, fifo_pop, drop;
  logic       fifo_full, fifo_empty, fwd_hit;
  logic [7:0] fwd_data;
  oam_wr_t    fifo_head, new_entry;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic       ram_we;

  assign wr_oamaddr = (cpu_addr == OAMADDR_REG) &&  cpu_write_en;
  assign rd_oamaddr = (cpu_addr == OAMADDR_REG) && !cpu_write_en;
  assign wr_oamdata = (cpu_addr == OAMDATA_REG) &&  cpu_write_en;
  assign rd_oamdata = (cpu_addr == OAMDATA_REG) && !cpu_write_en;

  // Port priority: PPU read, CPU data read, FIFO commit, direct write.
  // A data read and a data write never coincide, so the direct write only
  // has to yield to the PPU and to older pending entries.
  assign cpu_rd_gnt = rd_oamdata && !ppu_rd_en;
  assign fifo_pop   = !fifo_empty && !ppu_rd_en && !rd_oamdata;
  assign direct_wr  = wr_oamdata && fifo_empty && !ppu_rd_en;
  assign fifo_push  = wr_oamdata && !direct_wr;
  assign drop       = fifo_push && fifo_full && !fifo_pop;
  assign new_entry  = '{addr: oam_addr_out, data: cpu_data_in};

  oam_wr_fifo #(.DEPTH(PEND_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (new_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (pend_count),
    .lk_addr    (oam_addr_out),
    .lk_hit     (fwd_hit),
    .lk_data    (fwd_data)
  );

  // Single RAM port address/write mux following the priority above.
  always_comb begin
    ram_addr  = ppu_rd_addr;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (ppu_rd_en) begin
      ram_addr = ppu_rd_addr;
    end else if (cpu_rd_gnt) begin
      ram_addr = oam_addr_out;
    end else if (fifo_pop) begin
      ram_addr  = fifo_head.addr;
      ram_we    = 1'b1;
      ram_wdata = fifo_head.data;
    end else if (direct_wr) begin
      ram_addr  = oam_addr_out;
      ram_we    = 1'b1;
      ram_wdata = cpu_data_in;
    end
  end

  assign ram_rdata = mem[ram_addr];

  // OAM array; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  // OAMADDR, read-data registers and the sticky drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oam_addr_out <= '0;
      cpu_data_out <= '0;
      ppu_rd_data  <= '0;
      wr_drop      <= 1'b0;
    end else begin
      if (wr_oamaddr)      oam_addr_out <= cpu_data_in;
      else if (wr_oamdata) oam_addr_out <= oam_addr_out + 8'd1;

      if (rd_oamaddr)      cpu_data_out <= oam_addr_out;
      else if (rd_oamdata) begin
        if (fwd_hit)         cpu_data_out <= fwd_data;
        else if (cpu_rd_gnt) cpu_data_out <= ram_rdata;
        else                 cpu_data_out <= RD_COLLIDE_VAL;
      end

      if (ppu_rd_en) ppu_rd_data <= ram_rdata;
      if (drop)      wr_drop     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_oam_reg_port.sv
// Self-checking bench for oam_reg_port: register vector table, DMA fill,
// collision buffering, forwarding and reset during drain.
module tb_oam_reg_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_write_en;
  logic [7:0]  cpu_data_out;
  logic        ppu_rd_en;
  logic [7:0]  ppu_rd_addr;
  logic [7:0]  ppu_rd_data;
  logic [7:0]  oam_addr_out;
  logic [1:0]  pend_count;
  logic        wr_drop;

  int errs = 0;
  int checks = 0;

  logic [7:0] sb_q [$];
  logic [7:0] sb_exp;

  typedef struct {
    logic [15:0] addr;
    bit          we;
    logic [7:0]  din;
    bit          rd;
    logic [7:0]  exp_dout;
    logic [7:0]  exp_oa;
  } vec_t;

  vec_t vt [11];

  oam_reg_port #(.PEND_DEPTH(2), .RD_COLLIDE_VAL(8'hFF)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_addr     (cpu_addr),
    .cpu_data_in  (cpu_data_in),
    .cpu_write_en (cpu_write_en),
    .cpu_data_out (cpu_data_out),
    .ppu_rd_en    (ppu_rd_en),
    .ppu_rd_addr  (ppu_rd_addr),
    .ppu_rd_data  (ppu_rd_data),
    .oam_addr_out (oam_addr_out),
    .pend_count   (pend_count),
    .wr_drop      (wr_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [15:0] a, input bit we, input logic [7:0] d);
    cpu_addr     = a;
    cpu_write_en = we;
    cpu_data_in  = d;
    tick();
    cpu_addr     = 16'h0000;
    cpu_write_en = 1'b0;
    cpu_data_in  = 8'h00;
  endtask

  task automatic cpu_rd(input logic [15:0] a, input logic [7:0] exp, input string name);
    sb_q.push_back(exp);
    bus(a, 1'b0, 8'h00);
    sb_exp = sb_q.pop_front();
    chk(name, cpu_data_out, sb_exp);
  endtask

  task automatic ppu_rd(input logic [7:0] a, input logic [7:0] exp, input string name);
    sb_q.push_back(exp);
    ppu_rd_en   = 1'b1;
    ppu_rd_addr = a;
    tick();
    ppu_rd_en   = 1'b0;
    sb_exp = sb_q.pop_front();
    chk(name, ppu_rd_data, sb_exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dout"},  cpu_data_out, 8'h00);
    chk({tag, "_ppud"},  ppu_rd_data,  8'h00);
    chk({tag, "_oa"},    oam_addr_out, 8'h00);
    chk({tag, "_pend"},  {6'b0, pend_count}, 8'h00);
    chk({tag, "_drop"},  {7'b0, wr_drop},    8'h00);
  endtask

  initial begin
    rst = 1'b0; cpu_addr = '0; cpu_data_in = '0; cpu_write_en = 1'b0;
    ppu_rd_en = 1'b0; ppu_rd_addr = '0;

    // OAMADDR/OAMDATA register vectors, including the 0xFF wrap and an undecoded write.
    vt[0]  = '{16'h2003, 1'b1, 8'h10, 1'b0, 8'h00, 8'h10};
    vt[1]  = '{16'h2004, 1'b1, 8'hAA, 1'b0, 8'h00, 8'h11};
    vt[2]  = '{16'h2004, 1'b1, 8'hBB, 1'b0, 8'h00, 8'h12};
    vt[3]  = '{16'h2003, 1'b0, 8'h00, 1'b1, 8'h12, 8'h12};
    vt[4]  = '{16'h2003, 1'b1, 8'h10, 1'b0, 8'h00, 8'h10};
    vt[5]  = '{16'h2004, 1'b0, 8'h00, 1'b1, 8'hAA, 8'h10};
    vt[6]  = '{16'h2003, 1'b1, 8'hFF, 1'b0, 8'h00, 8'hFF};
    vt[7]  = '{16'h2004, 1'b1, 8'h11, 1'b0, 8'h00, 8'h00};
    vt[8]  = '{16'h2005, 1'b1, 8'h33, 1'b0, 8'h00, 8'h00};
    vt[9]  = '{16'h0003, 1'b1, 8'h44, 1'b0, 8'h00, 8'h00};
    vt[10] = '{16'h2003, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00};

    #2 rst = 1'b1;
    #2 chk_reset_outputs("reset");
    tick();
    rst = 1'b0;

    // Vector table.
    for (int i = 0; i < 11; i++) begin
      if (vt[i].rd) sb_q.push_back(vt[i].exp_dout);
      bus(vt[i].addr, vt[i].we, vt[i].din);
      if (vt[i].rd) begin
        sb_exp = sb_q.pop_front();
        chk($sformatf("vec%0d_dout", i), cpu_data_out, sb_exp);
      end
      chk($sformatf("vec%0d_oa", i), oam_addr_out, vt[i].exp_oa);
    end
    ppu_rd(8'hFF, 8'h11, "wrap_ppu_ff");
    tick();
    chk("ppu_hold", ppu_rd_data, 8'h11);

    // DMA-style fill of all 256 bytes, one write every 3 cycles.
    bus(16'h2003, 1'b1, 8'h40);
    cpu_rd(16'h2003, 8'h40, "dma_rd_oamaddr");
    bus(16'h2003, 1'b1, 8'h00);
    for (int i = 0; i < 256; i++) begin
      bus(16'h2004, 1'b1, 8'(i) ^ 8'h5A);
      tick();
      tick();
    end
    chk("dma_oa_wrapped", oam_addr_out, 8'h00);
    bus(16'h2003, 1'b1, 8'h40);
    chk("dma_oa_restore", oam_addr_out, 8'h40);
    begin
      int bad = 0;
      for (int i = 0; i < 256; i++) begin
        sb_q.push_back(8'(i) ^ 8'h5A);
        ppu_rd_en = 1'b1; ppu_rd_addr = 8'(i);
        tick();
        sb_exp = sb_q.pop_front();
        if (ppu_rd_data !== sb_exp) bad++;
      end
      ppu_rd_en = 1'b0;
      chk("dma_readback_bad_bytes", 8'(bad), 8'h00);
    end

    // Collision buffering: PPU holds the port for 5 cycles.
    bus(16'h2003, 1'b1, 8'h30);
    ppu_rd_en = 1'b1; ppu_rd_addr = 8'h00;
    bus(16'h2004, 1'b1, 8'hC1);
    chk("coll_pend1", {6'b0, pend_count}, 8'd1);
    bus(16'h2004, 1'b1, 8'hC2);
    chk("coll_pend2", {6'b0, pend_count}, 8'd2);
    chk("coll_nodrop", {7'b0, wr_drop}, 8'd0);
    bus(16'h2004, 1'b1, 8'hC3);
    chk("coll_drop", {7'b0, wr_drop}, 8'd1);
    chk("coll_oa", oam_addr_out, 8'h33);
    tick(); tick();
    chk("coll_hold_pend", {6'b0, pend_count}, 8'd2);
    chk("coll_ppu_data", ppu_rd_data, 8'h5A);
    ppu_rd_en = 1'b0;
    tick();
    chk("drain_pend1", {6'b0, pend_count}, 8'd1);
    tick();
    chk("drain_pend0", {6'b0, pend_count}, 8'd0);
    ppu_rd(8'h30, 8'hC1, "drain_30");
    ppu_rd(8'h31, 8'hC2, "drain_31");
    ppu_rd(8'h32, 8'h68, "dropped_32");

    // Forwarding while the PPU owns the port.
    ppu_rd_en = 1'b1; ppu_rd_addr = 8'h00;
    bus(16'h2003, 1'b1, 8'h20);
    bus(16'h2004, 1'b1, 8'h77);
    chk("fwd_pend", {6'b0, pend_count}, 8'd1);
    bus(16'h2003, 1'b1, 8'h20);
    cpu_rd(16'h2004, 8'h77, "fwd_hit");
    chk("fwd_no_inc", oam_addr_out, 8'h20);
    bus(16'h2003, 1'b1, 8'h21);
    cpu_rd(16'h2004, 8'hFF, "collide_val");
    chk("drop_sticky", {7'b0, wr_drop}, 8'd1);
    ppu_rd_en = 1'b0;
    tick();
    chk("fwd_drained", {6'b0, pend_count}, 8'd0);
    ppu_rd(8'h20, 8'h77, "fwd_committed");
    cpu_rd(16'h2004, 8'h7B, "cpu_ram_read");

    // Youngest of two same-address entries is forwarded and lands last.
    ppu_rd_en = 1'b1; ppu_rd_addr = 8'h00;
    bus(16'h2003, 1'b1, 8'h60);
    bus(16'h2004, 1'b1, 8'hA1);
    bus(16'h2003, 1'b1, 8'h60);
    bus(16'h2004, 1'b1, 8'hA2);
    bus(16'h2003, 1'b1, 8'h60);
    cpu_rd(16'h2004, 8'hA2, "fwd_youngest");
    ppu_rd_en = 1'b0;
    tick(); tick();
    ppu_rd(8'h60, 8'hA2, "order_60");

    // Reset clears the drop flag; then full FIFO with push+pop, then reset mid-drain.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_clears_drop", {7'b0, wr_drop}, 8'd0);
    bus(16'h2003, 1'b1, 8'h50);
    ppu_rd_en = 1'b1; ppu_rd_addr = 8'h00;
    bus(16'h2004, 1'b1, 8'hD1);
    bus(16'h2004, 1'b1, 8'hD2);
    chk("mid_pend2", {6'b0, pend_count}, 8'd2);
    ppu_rd_en = 1'b0;
    bus(16'h2004, 1'b1, 8'hD3);
    chk("pushpop_full_pend", {6'b0, pend_count}, 8'd2);
    chk("pushpop_full_nodrop", {7'b0, wr_drop}, 8'd0);
    rst = 1'b1;
    #1 chk_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    ppu_rd(8'h50, 8'hD1, "mid_50_committed");
    ppu_rd(8'h51, 8'h0B, "mid_51_discarded");
    ppu_rd(8'h52, 8'h08, "mid_52_discarded");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
